// File: rtl/mfp_window_feeder.sv
// Sliding-window feeder: turns a pixel stream into centred ArrL-tap windows, one per column.
// Border padding repeats the edge pixel; define MFP_WINFEED_ZEROPAD_EN to pad with zeros instead.
module mfp_window_feeder #(
  parameter int DataW   = 8,
  parameter int ArrL    = 19,
  parameter int LineLen = 64,
  localparam int XW     = (LineLen > 1) ? $clog2(LineLen) : 1
) (
  input  logic                  clk_,
  input  logic                  rst_n,
  input  logic [DataW-1:0]      in_pix,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ArrL*DataW-1:0] out_win,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         out_x,
  output logic                  out_last
);

  // state | meaning
  // IDLE  | waiting for first pixel of a line
  // FILL  | shifting in pixels until the column-0 window is centred
  // RUN   | one window per accepted pixel
  // FLUSH | shifting in right-border pad until the last column is emitted
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam int Half = (ArrL - 1) / 2;
  localparam int WinW = ArrL * DataW;

  state_t          state_q, state_d;
  logic [WinW-1:0] win_q, win_d;
  logic            valid_q, valid_d;
  logic [XW-1:0]   x_q, x_d;
  logic            last_q, last_d;
  logic [XW-1:0]   cnt_q, cnt_d;
  logic            out_free;

  function automatic logic [WinW-1:0] shift_in(input logic [WinW-1:0] w, input logic [DataW-1:0] p);
    return {w[WinW-DataW-1:0], p};
  endfunction

  function automatic logic [WinW-1:0] line_start(input logic [DataW-1:0] p);
`ifdef MFP_WINFEED_ZEROPAD_EN
    return {{(WinW-DataW){1'b0}}, p};
`else
    return {ArrL{p}};
`endif
  endfunction

  function automatic logic [DataW-1:0] end_pad(input logic [WinW-1:0] w);
`ifdef MFP_WINFEED_ZEROPAD_EN
    return (w[DataW-1:0] & '0);
`else
    return w[DataW-1:0];
`endif
  endfunction

  assign out_free = !valid_q || out_ready;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    valid_d  = valid_q;
    x_d      = x_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          win_d   = line_start(in_pix);
          cnt_d   = XW'(1);
          x_d     = '0;
          last_d  = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          win_d = shift_in(win_q, in_pix);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == XW'(Half)) begin
            valid_d = 1'b1;
            x_d     = '0;
            state_d = (cnt_q == XW'(LineLen - 1)) ? FLUSH : RUN;
          end
        end
      end
      RUN: begin
        in_ready = out_free;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (in_valid && out_free) begin
          win_d   = shift_in(win_q, in_pix);
          valid_d = 1'b1;
          x_d     = x_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == XW'(LineLen - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The last-column window stays until consumed; nothing else is pending.
        if (valid_q && last_q) begin
          if (out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            x_d     = '0;
            state_d = IDLE;
          end
        end else if (out_free) begin
          win_d   = shift_in(win_q, end_pad(win_q));
          valid_d = 1'b1;
          x_d     = x_q + 1'b1;
          last_d  = (x_q == XW'(LineLen - 2));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_win   = win_q;
  assign out_valid = valid_q;
  assign out_x     = x_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_mfp_window_feeder.sv
// Scoreboard bench for mfp_window_feeder (ArrL=5, LineLen=8, DataW=8).
// Expected windows come from a clamp/zero-pad model over the accepted line pixels.
module tb_mfp_window_feeder;
  localparam int DW = 8;
  localparam int AL = 5;
  localparam int LL = 8;
  localparam int HF = 2;
  localparam int XW = 3;
`ifdef MFP_WINFEED_ZEROPAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     in_pix = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AL*DW-1:0]  out_win;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [XW-1:0]     out_x;
  logic              out_last;

  mfp_window_feeder #(.DataW(DW), .ArrL(AL), .LineLen(LL)) dut (
    .clk_(clk), .rst_n(rst_n), .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
    .out_win(out_win), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AL*DW-1:0] win;
    int               x;
    bit               last;
  } exp_t;

  exp_t q[$];
  int   line_pix[LL];
  int   lidx = 0;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;
  int   stall_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [AL*DW-1:0] model_win(input int x);
    logic [AL*DW-1:0] w;
    w = '0;
    for (int t = 0; t < AL; t++) begin
      int col;
      int v;
      col = x + HF - t;
      if (col < 0) v = ZP ? 0 : line_pix[0];
      else if (col > LL - 1) v = ZP ? 0 : line_pix[LL-1];
      else v = line_pix[col];
      w[t*DW +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  function automatic void push_exp(input int x);
    exp_t e;
    e.win  = model_win(x);
    e.x    = x;
    e.last = (x == LL - 1);
    q.push_back(e);
  endfunction

  // Accept snooper: records line pixels and queues each window once it is fully determined.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        lidx = 0;
      end else if (in_valid && in_ready) begin
        if (lidx == 0) chk("line_start_idle", {63'd0, out_valid}, 64'd0);
        line_pix[lidx] = int'(in_pix);
        if (lidx >= HF) push_exp(lidx - HF);
        if (lidx == LL - 1)
          for (int x = LL - HF; x < LL; x++) push_exp(x);
        lidx = (lidx + 1) % LL;
      end
    end
  end

  // Output monitor: pops and compares on every consumed window, checks stall hold.
  initial begin
    bit               have_prev;
    logic [AL*DW-1:0] pw;
    logic [XW-1:0]    px;
    logic             pl;
    exp_t             e;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          chk("hold_win", {24'd0, out_win}, {24'd0, pw});
          chk("hold_x", {61'd0, out_x}, {61'd0, px});
          chk("hold_last", {63'd0, out_last}, {63'd0, pl});
        end
        if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_window", {61'd0, out_x}, 64'hFFFF);
          end else begin
            e = q.pop_front();
            chk("win", {24'd0, out_win}, {24'd0, e.win});
            chk("x", {61'd0, out_x}, 64'(e.x));
            chk("last", {63'd0, out_last}, {63'd0, e.last});
          end
        end
        have_prev = out_valid && !out_ready;
        pw = out_win;
        px = out_x;
        pl = out_last;
      end
    end
  end

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom % 3) != 0;
        default: begin
          if (out_valid && out_x == 3'd3 && stall_n < 4) begin
            out_ready = 1'b0;
            stall_n++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic send_pixel(input int v, input bit gaps);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end
    in_pix   = v[DW-1:0];
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_valid && in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int base, input bit rnd, input bit gaps);
    for (int i = 0; i < LL; i++)
      send_pixel(rnd ? int'($urandom % 256) : base + i, gaps);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_win", {24'd0, out_win}, 64'd0);
    chk("rst_x", {61'd0, out_x}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    rdy_mode = 0;
    send_line(1, 1'b0, 1'b0);
    drain();

    rdy_mode = 2;
    stall_n  = 0;
    send_line(1, 1'b0, 1'b0);
    drain();
    chk("stall_applied", 64'(stall_n), 64'd4);

    rdy_mode = 0;
    send_line(1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_win", {24'd0, out_win}, 64'd0);
    chk("midrst_x", {61'd0, out_x}, 64'd0);
    chk("midrst_last", {63'd0, out_last}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    send_line(9, 1'b0, 1'b0);
    drain();

    send_line(1, 1'b0, 1'b0);
    send_line(21, 1'b0, 1'b0);
    drain();

    rdy_mode = 1;
    for (int l = 0; l < 6; l++) send_line(0, 1'b1, 1'b1);
    drain();
    rdy_mode = 0;
    send_line(0, 1'b1, 1'b1);
    send_line(0, 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mfp_window_feeder.md
MFP_WINDOW_FEEDER -- requirements
Module: mfp_window_feeder

Interface
REQ-001 SHALL take parameter DataW, default 8: pixel width in bits.
REQ-002 SHALL take parameter ArrL, default 19: window taps; odd, >=3; Half=(ArrL-1)/2.
REQ-003 SHALL take parameter LineLen, default 64: pixels per line; LineLen>Half.
REQ-004 SHALL have port clk_  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_pix  input  DataW  incoming pixel.
REQ-007 SHALL have port in_valid  input  1  in_pix valid.
REQ-008 SHALL have port in_ready  output  1  pixel accepted when in_valid&&in_ready.
REQ-009 SHALL have port out_win  output  ArrL*DataW  window for a MAC; newest tap in bits [DataW-1:0], oldest in the top slot.
REQ-010 SHALL have port out_valid  output  1  out_win holds a centred window.
REQ-011 SHALL have port out_ready  input  1  window consumed when out_valid&&out_ready.
REQ-012 SHALL have port out_x  output  clog2(LineLen)  column of the window's centre pixel.
REQ-013 SHALL have port out_last  output  1  window is centred on column LineLen-1.

Function
REQ-014 SHALL implement states IDLE, FILL, RUN, FLUSH.
REQ-015 IDLE: in_ready=1; on accept of the first pixel p0 of a line, load all ArrL taps with p0 (pad value, see REQ-025); go to FILL.
REQ-016 FILL: in_ready=1; each accept shifts in one pixel; on the Half-th accept, assert out_valid with out_x=0 next cycle; go to RUN.
REQ-017 RUN: in_ready = !out_valid || out_ready; each accept shifts the window and presents the next window, out_x incremented by 1.
REQ-018 On accept of pixel LineLen-1 SHALL go to FLUSH; FLUSH: in_ready=0; Half further shifts of the pad value, each only when !out_valid||out_ready.
REQ-019 SHALL emit exactly LineLen windows per line, in column order, none dropped or duplicated.
REQ-020 The window with out_x=LineLen-1 SHALL carry out_last=1; its consumption returns the block to IDLE.
REQ-021 While out_valid=1 and out_ready=0, out_win, out_x and out_last SHALL hold and no shift SHALL occur.
REQ-022 Latency: a window SHALL become valid the cycle after the accept (or flush shift) completing it; full throughput of 1 window/cycle with out_ready=1.
REQ-023 Back-to-back lines: a pixel presented during FLUSH SHALL wait; it is accepted in IDLE no earlier than the cycle after the out_last window is consumed.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_last=0, out_x=0, out_win=0, column counters=0, in_ready=1 after release, in any state including mid-line.

Configuration
REQ-025 Macro MFP_WINFEED_ZEROPAD_EN: defined -> all border pad taps (IDLE load, FLUSH shifts) SHALL be 0; undefined -> pad with the edge pixel (p0 at line start, last pixel at line end).

Verification (ArrL=5, LineLen=8, DataW=8; windows listed oldest->newest)
REQ-026 Reset with in_valid=0 -> out_valid=0, out_win=0, in_ready=1, out_x=0.
REQ-027 Line 1..8, out_ready=1, macro undefined -> 8 windows: first {1,1,1,2,3} out_x=0; fourth {2,3,4,5,6} out_x=3; last {6,7,8,8,8} out_x=7 out_last=1.
REQ-028 Same line, out_ready=0 for 4 cycles at out_x=3 -> out_win={2,3,4,5,6} held, in_ready=0, remaining windows match REQ-027 exactly.
REQ-029 Macro defined, line 1..8 -> first {0,0,1,2,3}, last {6,7,8,0,0}.
REQ-030 rst_n pulsed low during FLUSH -> outputs cleared same cycle; then line 9..16 -> first window {9,9,9,10,11}.
REQ-031 Two lines 1..8, 21..28, in_valid held 1 -> 16 windows in order, pixel 21 accepted only after {6,7,8,8,8} consumed, second first window {21,21,21,22,23}.
